fetch_redirect_control: RTL and testbench

FETCH_REDIRECT_CONTROL -- requirements
Module: fetch_redirect_control

---
 rtl/fetch_redirect_control_pkg.sv | 22 ++
 rtl/fetch_redirect_control_if.sv | 30 +++
 rtl/fetch_redirect_control_stall_counter.sv | 44 ++++
 rtl/fetch_redirect_control.sv | 142 ++++++++++++++
 tb/tb_fetch_redirect_control.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_control_pkg.sv
// Shared definitions for the fetch redirect controller: FSM encoding,
// reset PC and instruction alignment helpers.
package fetch_redirect_control_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        PEND  = 2'd2
    } redirectState_t;

    localparam logic [31:0] RESET_PC         = 32'h0000_3000;
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] alignTarget(input logic [31:0] addr, input bit checkEn);
        return checkEn ? (addr & INSTR_ALIGN_MASK) : addr;
    endfunction

    function automatic logic isMisaligned(input logic [1:0] lowBits, input bit checkEn);
        return checkEn && (lowBits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_redirect_control_if.sv
// Handshake bundle between the ID/hazard side and the fetch redirect controller.
interface fetch_redirect_control_if #(
    parameter int CNT_W = 4
);
    logic             brValid;
    logic             brTaken;
    logic [31:0]      brTarget;
    logic             stallReq;
    logic [CNT_W-1:0] stallCycles;
    logic             freezeAck;
    logic             jumpEnabled;
    logic [31:0]      jumpInput;
    logic             setFreezeTime;
    logic             flushIFID;
    logic             busy;
    logic             errMisalign;
    logic             errOverrun;

    modport master (
        output brValid, brTaken, brTarget, stallReq, stallCycles, freezeAck,
        input  jumpEnabled, jumpInput, setFreezeTime, flushIFID, busy,
               errMisalign, errOverrun
    );

    modport slave (
        input  brValid, brTaken, brTarget, stallReq, stallCycles, freezeAck,
        output jumpEnabled, jumpInput, setFreezeTime, flushIFID, busy,
               errMisalign, errOverrun
    );
endinterface

// File: rtl/fetch_redirect_control_stall_counter.sv
// Freeze-length down-counter: loads max(req,1), decrements while active and
// merges new requests so a running freeze is never shortened.
module fetch_redirect_control_stall_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             active,
    input  logic             mergeReq,
    input  logic [CNT_W-1:0] reqCycles,
    output logic             nextZero
);
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic [CNT_W-1:0] reqMin1;
    logic [CNT_W-1:0] decremented;

    always_comb begin
        reqMin1     = (reqCycles == '0) ? CNT_W'(1) : reqCycles;
        decremented = (count == '0) ? '0 : count - CNT_W'(1);
        countNext   = count;
        if (start) begin
            countNext = reqMin1;
        end else if (active) begin
            countNext = decremented;
            if (mergeReq && (reqMin1 > decremented)) begin
                countNext = reqMin1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= countNext;
        end
    end

    // The FSM decides on the post-update value, so expose it directly.
    assign nextZero = (countNext == '0);

endmodule

// File: rtl/fetch_redirect_control.sv
// Fetch redirect controller: sequences PC freezes and branch redirects,
// buffering a redirect that arrives while the PC is frozen.
//
// state | meaning
// RUN   | no freeze; taken branches redirect the PC immediately
// STALL | freeze counting, no redirect buffered
// PEND  | freeze counting, redirect buffered in pendReg
module fetch_redirect_control
    import fetch_redirect_control_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    fetch_redirect_control_if.slave  bus
);
    redirectState_t state;
    redirectState_t stateNext;

    logic [31:0] pendReg;
    logic [31:0] pendNext;
    logic        jumpEnNext;
    logic [31:0] jumpInNext;
    logic        freezeNext;
    logic        flushNext;
    logic        errMisNext;
    logic        errOvrNext;

    logic        taken;
    logic [31:0] target;
    logic        misaligned;
    logic        cntNextZero;
    logic        cntStart;
    logic        cntActive;

    assign taken      = bus.brValid & bus.brTaken;
    assign target     = alignTarget(bus.brTarget, ALIGN_CHECK);
    assign misaligned = isMisaligned(bus.brTarget[1:0], ALIGN_CHECK);
    assign cntStart   = (state == RUN) && bus.stallReq;
    assign cntActive  = (state != RUN);

    fetch_redirect_control_stall_counter #(
        .CNT_W (CNT_W)
    ) uStallCounter (
        .clock     (clock),
        .reset     (reset),
        .start     (cntStart),
        .active    (cntActive),
        .mergeReq  (bus.stallReq),
        .reqCycles (bus.stallCycles),
        .nextZero  (cntNextZero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= RUN;
            pendReg           <= '0;
            bus.jumpEnabled   <= 1'b0;
            bus.jumpInput     <= RESET_PC;
            bus.setFreezeTime <= 1'b0;
            bus.flushIFID     <= 1'b0;
            bus.busy          <= 1'b0;
            bus.errMisalign   <= 1'b0;
            bus.errOverrun    <= 1'b0;
        end else begin
            state             <= stateNext;
            pendReg           <= pendNext;
            bus.jumpEnabled   <= jumpEnNext;
            bus.jumpInput     <= jumpInNext;
            bus.setFreezeTime <= freezeNext;
            bus.flushIFID     <= flushNext;
            bus.busy          <= (stateNext != RUN);
            bus.errMisalign   <= errMisNext;
            bus.errOverrun    <= errOvrNext;
        end
    end

    always_comb begin
        stateNext  = state;
        pendNext   = pendReg;
        jumpEnNext = 1'b0;
        jumpInNext = bus.jumpInput;
        freezeNext = 1'b0;
        flushNext  = 1'b0;
        errMisNext = bus.errMisalign | (taken & misaligned);
        // A freeze the PC did not acknowledge is a protocol error.
        errOvrNext = bus.errOverrun | (bus.setFreezeTime & ~bus.freezeAck);

        case (state)
            RUN: begin
                if (bus.stallReq) begin
                    freezeNext = 1'b1;
                    if (taken) begin
                        pendNext  = target;
                        stateNext = PEND;
                    end else begin
                        stateNext = STALL;
                    end
                end else if (taken) begin
                    jumpEnNext = 1'b1;
                    flushNext  = 1'b1;
                    jumpInNext = target;
                end
            end
            STALL: begin
                if (cntNextZero) begin
                    stateNext = RUN;
                    if (taken) begin
                        jumpEnNext = 1'b1;
                        flushNext  = 1'b1;
                        jumpInNext = target;
                    end
                end else begin
                    freezeNext = 1'b1;
                    if (taken) begin
                        pendNext  = target;
                        stateNext = PEND;
                    end
                end
            end
            PEND: begin
                if (taken) begin
                    pendNext   = target;
                    errOvrNext = 1'b1;
                end
                if (cntNextZero) begin
                    stateNext  = RUN;
                    jumpEnNext = 1'b1;
                    flushNext  = 1'b1;
                    jumpInNext = taken ? target : pendReg;
                end else begin
                    freezeNext = 1'b1;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_redirect_control.sv
// Directed bench for fetch_redirect_control with hand-computed expectations.
module tb_fetch_redirect_control;
    logic clock;
    logic reset;
    int   errCount;
    int   checkCount;

    fetch_redirect_control_if #(.CNT_W(4)) bus ();

    fetch_redirect_control #(
        .CNT_W       (4),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic je, input logic [31:0] ji,
                            input logic sf, input logic fl, input logic bs);
        checkVal({tag, "/jumpEnabled"},   32'(bus.jumpEnabled),   32'(je));
        checkVal({tag, "/jumpInput"},     bus.jumpInput,          ji);
        checkVal({tag, "/setFreezeTime"}, 32'(bus.setFreezeTime), 32'(sf));
        checkVal({tag, "/flushIFID"},     32'(bus.flushIFID),     32'(fl));
        checkVal({tag, "/busy"},          32'(bus.busy),          32'(bs));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.brValid     = 1'b0;
        bus.brTaken     = 1'b0;
        bus.brTarget    = 32'h0;
        bus.stallReq    = 1'b0;
        bus.stallCycles = 4'd0;
        bus.freezeAck   = 1'b1;
    endtask

    task automatic branch(input logic [31:0] tgt);
        bus.brValid  = 1'b1;
        bus.brTaken  = 1'b1;
        bus.brTarget = tgt;
    endtask

    task automatic stall(input logic [3:0] n);
        bus.stallReq    = 1'b1;
        bus.stallCycles = n;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        reset      = 1'b0;
        idle();

        // Reset values before any clock edge
        #2 reset = 1'b1;
        #2;
        checkOut("reset", 1'b0, 32'h3000, 1'b0, 1'b0, 1'b0);
        checkVal("reset/errMisalign", 32'(bus.errMisalign), 32'd0);
        checkVal("reset/errOverrun",  32'(bus.errOverrun),  32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Taken branch in RUN
        branch(32'h3040);
        tick();
        checkOut("br3040", 1'b1, 32'h3040, 1'b0, 1'b1, 1'b0);
        idle();
        tick();
        checkOut("br3040+1", 1'b0, 32'h3040, 1'b0, 1'b0, 1'b0);

        // Not-taken branch is ignored
        bus.brValid  = 1'b1;
        bus.brTaken  = 1'b0;
        bus.brTarget = 32'h5000;
        tick();
        checkOut("notTaken", 1'b0, 32'h3040, 1'b0, 1'b0, 1'b0);
        idle();

        // Three-cycle freeze
        stall(4'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
            checkVal($sformatf("stall3/sf%0d", i),   32'(bus.setFreezeTime), 32'(i < 3));
            checkVal($sformatf("stall3/busy%0d", i), 32'(bus.busy),          32'(i < 3));
            checkVal($sformatf("stall3/je%0d", i),   32'(bus.jumpEnabled),   32'd0);
        end

        // Freeze plus branch in the same cycle
        stall(4'd2);
        branch(32'h3100);
        tick();
        idle();
        checkOut("pend3100/c1", 1'b0, 32'h3040, 1'b1, 1'b0, 1'b1);
        tick();
        checkOut("pend3100/c2", 1'b0, 32'h3040, 1'b1, 1'b0, 1'b1);
        tick();
        checkOut("pend3100/jump", 1'b1, 32'h3100, 1'b0, 1'b1, 1'b0);
        tick();
        checkOut("pend3100/after", 1'b0, 32'h3100, 1'b0, 1'b0, 1'b0);
        checkVal("pre-overrun/errOverrun", 32'(bus.errOverrun), 32'd0);

        // Two branches during a four-cycle freeze
        stall(4'd4);
        tick();
        idle();
        branch(32'h3200);
        tick();
        idle();
        checkOut("ovr/first", 1'b0, 32'h3100, 1'b1, 1'b0, 1'b1);
        branch(32'h3300);
        tick();
        idle();
        checkVal("ovr/errOverrun", 32'(bus.errOverrun), 32'd1);
        tick();
        checkOut("ovr/c4", 1'b0, 32'h3100, 1'b1, 1'b0, 1'b1);
        tick();
        checkOut("ovr/jump", 1'b1, 32'h3300, 1'b0, 1'b1, 1'b0);
        checkVal("ovr/errMisalign", 32'(bus.errMisalign), 32'd0);

        // Asynchronous reset while a redirect is pending
        stall(4'd5);
        branch(32'h3400);
        tick();
        idle();
        checkVal("rstPend/busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOut("rstPend/async", 1'b0, 32'h3000, 1'b0, 1'b0, 1'b0);
        checkVal("rstPend/errOverrun", 32'(bus.errOverrun), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOut($sformatf("rstPend/post%0d", i), 1'b0, 32'h3000, 1'b0, 1'b0, 1'b0);
        end

        // Misaligned target
        branch(32'h3006);
        tick();
        idle();
        checkOut("misalign", 1'b1, 32'h3004, 1'b0, 1'b1, 1'b0);
        checkVal("misalign/errMisalign", 32'(bus.errMisalign), 32'd1);
        checkVal("misalign/errOverrun",  32'(bus.errOverrun),  32'd0);
        tick();

        // Freeze without acknowledge from the PC
        stall(4'd2);
        bus.freezeAck = 1'b0;
        tick();
        bus.stallReq = 1'b0;
        checkVal("noAck/c1/errOverrun", 32'(bus.errOverrun), 32'd0);
        tick();
        idle();
        checkVal("noAck/c2/errOverrun", 32'(bus.errOverrun), 32'd1);
        checkVal("noAck/c2/sf",         32'(bus.setFreezeTime), 32'd1);
        tick();
        checkVal("noAck/end/sf",        32'(bus.setFreezeTime), 32'd0);

        // stallCycles=0 behaves as a single cycle
        stall(4'd0);
        tick();
        idle();
        checkVal("stall0/sf", 32'(bus.setFreezeTime), 32'd1);
        tick();
        checkVal("stall0/end/sf", 32'(bus.setFreezeTime), 32'd0);
        checkVal("stall0/end/busy", 32'(bus.busy), 32'd0);

        // Reload while frozen lengthens (2 then 4) but never shortens (5 then 1)
        for (int t = 0; t < 2; t++) begin
            stall((t == 0) ? 4'd2 : 4'd5);
            tick();
            stall((t == 0) ? 4'd4 : 4'd1);
            tick();
            idle();
            for (int i = 0; i < 5; i++) begin
                checkVal($sformatf("merge%0d/sf%0d", t, i), 32'(bus.setFreezeTime), 32'(i < 4));
                checkVal($sformatf("merge%0d/busy%0d", t, i), 32'(bus.busy), 32'(i < 4));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
